lbp_stream: RTL and testbench

LBP_STREAM -- requirements
Module: lbp_stream

---
 rtl/lbp_stream.sv | 115 +++++++++++
 tb/tb_lbp_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lbp_stream.sv
// Streaming 3x3 local binary pattern filter: RGB444 in, grey-rendered LBP code out, two-cycle latency.
// Optional build macro LBP_BYPASS_EN adds a bypass input that shows the window-centre gray instead.
module lbp_stream #(
  parameter int IMG_W = 400,
  parameter int IMG_H = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pix_in,
  input  logic        pix_valid,
  input  logic        sof,
`ifdef LBP_BYPASS_EN
  input  logic        bypass,
`endif
  output logic [11:0] out_pix,
  output logic        out_valid,
  output logic        frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0] x_cnt, cur_x;
  logic [YW-1:0] y_cnt, cur_y;
  logic [7:0]    gsum;
  logic [3:0]    gray;
  logic [3:0]    lb_a [IMG_W];
  logic [3:0]    lb_b [IMG_W];
  logic [3:0]    win  [3][3];
  logic          v1, mask1, last1;
  logic [7:0]    code;
  logic [3:0]    centre;
  logic [11:0]   result;
  logic          spare_unused;

  // sof forces the current pixel to (0,0) whatever the counters say
  always_comb begin
    cur_x = sof ? '0 : x_cnt;
    cur_y = sof ? '0 : y_cnt;
  end

  always_comb begin
    gsum = 8'd5 * {4'd0, pix_in[11:8]} + 8'd9 * {4'd0, pix_in[7:4]} + 8'd2 * {4'd0, pix_in[3:0]};
    gray = gsum[7:4];
  end

  // lb_a holds the previous row, lb_b the row before that; contents are never reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_a[cur_x] <= gray;
      lb_b[cur_x] <= lb_a[cur_x];
    end
  end

  always_comb begin
    centre  = win[1][1];
    code[7] = (win[0][0] >= centre);
    code[6] = (win[0][1] >= centre);
    code[5] = (win[0][2] >= centre);
    code[4] = (win[1][2] >= centre);
    code[3] = (win[2][2] >= centre);
    code[2] = (win[2][1] >= centre);
    code[1] = (win[2][0] >= centre);
    code[0] = (win[1][0] >= centre);
    result  = {code[7:4], code[7:4], code[7:4]};
`ifdef LBP_BYPASS_EN
    if (bypass) result = {centre, centre, centre};
`endif
    if (mask1) result = 12'h000;
  end

  // Only the upper code nibble reaches the grey display
  assign spare_unused = ^{code[3:0], gsum[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      v1         <= 1'b0;
      mask1      <= 1'b0;
      last1      <= 1'b0;
      out_pix    <= 12'h000;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= 4'd0;
    end else begin
      v1 <= pix_valid;
      if (pix_valid) begin
        if (cur_x == XW'(IMG_W - 1)) begin
          x_cnt <= '0;
          y_cnt <= (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
        end else begin
          x_cnt <= cur_x + XW'(1);
          y_cnt <= cur_y;
        end
        mask1 <= (int'(cur_x) < 2) || (int'(cur_y) < 2);
        last1 <= (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        // New right-hand column: two rows up, one row up, current pixel
        win[0][2] <= lb_b[cur_x];
        win[1][2] <= lb_a[cur_x];
        win[2][2] <= gray;
      end
      out_valid  <= v1;
      frame_done <= v1 && last1;
      if (v1) out_pix <= result;
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream: a 4x4 instance for pattern/gap tests, an 8x4 instance for resync/reset.
module tb_lbp_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        sof;
`ifdef LBP_BYPASS_EN
  logic        bypass;
`endif
  logic [11:0] op4, op8;
  logic        ov4, ov8, fd4, fd8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] q4[$];
  logic [12:0] q8[$];
  logic        ov_hist[$];
  logic        pv_hist[$];
  logic [11:0] img [16];
  logic [11:0] expv[16];

  always #5 clk = ~clk;

  lbp_stream #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
`ifdef LBP_BYPASS_EN
    .bypass(bypass),
`endif
    .out_pix(op4), .out_valid(ov4), .frame_done(fd4));

  lbp_stream #(.IMG_W(8), .IMG_H(4)) dut8 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
`ifdef LBP_BYPASS_EN
    .bypass(bypass),
`endif
    .out_pix(op8), .out_valid(ov8), .frame_done(fd8));

  always @(negedge clk) begin
    if (ov4) q4.push_back({fd4, op4});
    if (ov8) q8.push_back({fd8, op8});
    ov_hist.push_back(ov4);
    pv_hist.push_back(pix_valid);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [11:0] p, input logic s);
    pix_in = p; pix_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame4(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      px(img[i], i == 0);
      if (gaps) idle(1);
    end
    idle(4);
  endtask

  task automatic check_frame4(input string tag);
    chk({tag, "_count"}, q4.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_%0d", tag, i), (i < q4.size()) ? q4[i] : 13'bx, {(i == 15), expv[i]});
  endtask

  // Expected 8x4 output: interior positions white, frame_done on the last pixel of each frame
  function automatic logic [12:0] exp8(input int j, input int ofs);
    int k, x, y;
    k = j - ofs;
    if (k < 0) return 13'h000;
    x = k % 8;
    y = (k / 8) % 4;
    return {(k % 32) == 31, (x >= 2 && y >= 2) ? 12'hFFF : 12'h000};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic set_imgs(input logic [11:0] bg, input logic [11:0] c5);
    for (int i = 0; i < 16; i++) begin
      img[i]  = bg;
      expv[i] = 12'h000;
    end
    img[5] = c5;
  endtask

  initial begin
    int gs;
    rst = 1'b1; pix_in = 12'h000; pix_valid = 1'b0; sof = 1'b0;
`ifdef LBP_BYPASS_EN
    bypass = 1'b0;
`endif
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_pix", op4, 12'h000);
    chk("rst_frame_done", fd4, 0);
    chk("rst_out_valid8", ov8, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Flat white frame: only the four interior outputs see a complete window
    set_imgs(12'hFFF, 12'hFFF);
    expv[10] = 12'hFFF; expv[11] = 12'hFFF; expv[14] = 12'hFFF; expv[15] = 12'hFFF;
    q4.delete();
    send_frame4(0);
    check_frame4("flat");

    // Bright centre, dark neighbours
    set_imgs(12'h000, 12'hFFF);
    expv[10] = 12'h000; expv[11] = 12'hFFF; expv[14] = 12'hFFF; expv[15] = 12'hFFF;
    q4.delete();
    send_frame4(0);
    check_frame4("hot_centre");

    // Dark centre, bright neighbours; neighbouring windows expose bit0, bit6, bit7
    set_imgs(12'hFFF, 12'h000);
    expv[10] = 12'hFFF; expv[11] = 12'hFFF; expv[14] = 12'hBBB; expv[15] = 12'h777;
    q4.delete();
    send_frame4(0);
    check_frame4("cold_centre");

    // Bright top row, mid-grey centre (gray 8), dark elsewhere -> code E0
    set_imgs(12'h000, 12'h888);
    img[0] = 12'hFFF; img[1] = 12'hFFF; img[2] = 12'hFFF;
    expv[10] = 12'hEEE; expv[11] = 12'hFFF; expv[14] = 12'hFFF; expv[15] = 12'hFFF;
    q4.delete();
    send_frame4(0);
    check_frame4("top_row");

    // Same frame with pix_valid toggling 1010...
    q4.delete();
    gs = ov_hist.size();
    send_frame4(1);
    check_frame4("gapped");
    for (int n = gs + 2; n < ov_hist.size(); n++)
      chk($sformatf("gap_valid_c%0d", n - gs), ov_hist[n], pv_hist[n - 2]);

    // 8x4: sof at (5,1) resynchronises, then two full frames
    do_reset();
    q8.delete();
    for (int i = 0; i < 13; i++) px(12'hFFF, i == 0);
    for (int i = 0; i < 64; i++) px(12'hFFF, i == 0);
    idle(4);
    chk("sof_count", q8.size(), 77);
    for (int j = 0; j < 77; j++)
      chk($sformatf("sof_%0d", j), (j < q8.size()) ? q8[j] : 13'bx, exp8(j, 13));

    // Reset mid-frame: in-flight output dropped, next pixel is (0,0)
    q8.delete();
    for (int i = 0; i < 10; i++) px(12'hFFF, 1'b0);
    do_reset();
    chk("rst_drop_count", q8.size(), 9);
    q8.delete();
    for (int i = 0; i < 64; i++) px(12'hFFF, 1'b0);
    idle(4);
    chk("post_rst_count", q8.size(), 64);
    for (int j = 0; j < 64; j++)
      chk($sformatf("post_rst_%0d", j), (j < q8.size()) ? q8[j] : 13'bx, exp8(j, 0));

`ifdef LBP_BYPASS_EN
    // Bypass: 8C4 -> gray 9 shown at interior positions
    do_reset();
    bypass = 1'b1;
    set_imgs(12'h8C4, 12'h8C4);
    expv[10] = 12'h999; expv[11] = 12'h999; expv[14] = 12'h999; expv[15] = 12'h999;
    q4.delete();
    send_frame4(0);
    check_frame4("bypass");
    bypass = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
